// File: rtl/letter_game_ctrl.sv
// -----------------------------------------------------------------------------
// letter_game_ctrl
//   Game controller for the keyboard letter-reaction game. It takes decoded key
//   events from the keyboard wrapper and picks a pseudo-random goal letter from
//   a free-running 16-bit Galois LFSR. It times the player's reaction in
//   millisecond ticks and scores multi-round sessions. Every output is a
//   register, so it can drive the display mux, the LEDs and the loss animation
//   without glitches.
//
// Ports
//   clk_i         system clock
//   rst_n_i       synchronous active-low reset
//   key_valid_i   1-cycle strobe: a key event is present this cycle
//   key_break_i   qualifies key_valid_i: 1 = release, 0 = make
//   key_code_i    letter code of the event
//   state_o       FSM state: 0 IDLE, 1 PICK, 2 PLAY, 3 WIN, 4 LOSS, 5 DONE
//   goal_o        current goal letter (meaningful in PLAY/WIN)
//   score_o       correct hits in the current session
//   elapsed_ms_o  live ms count of the current round
//   react_ms_o    reaction time of the last correct hit
//   best_ms_o     best (minimum) reaction time since reset
//   win_pulse_o   1-cycle strobe on each correct hit
//   loss_pulse_o  1-cycle strobe on entering LOSS
//
// Key interface: the wrapper has no ready/back-pressure path. An event exists
// only in the single cycle key_valid_i is high, and it is consumed or dropped
// in that same cycle. Only make events (key_break_i = 0) can change state.
// Release events are ignored everywhere.
// -----------------------------------------------------------------------------
module letter_game_ctrl #(
   parameter int          CODE_W      = 5,
   parameter int          NUM_LETTERS = 26,
   parameter int          ROUNDS      = 8,
   parameter int          TICK_DIV    = 100000,
   parameter int          TIMEOUT_MS  = 2000,
   parameter int          HOLD_MS     = 500,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1,
   localparam int         SCW         = $clog2(ROUNDS + 1)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              key_valid_i,
   input  logic              key_break_i,
   input  logic [CODE_W-1:0] key_code_i,
   output logic [2:0]        state_o,
   output logic [CODE_W-1:0] goal_o,
   output logic [SCW-1:0]    score_o,
   output logic [15:0]       elapsed_ms_o,
   output logic [15:0]       react_ms_o,
   output logic [15:0]       best_ms_o,
   output logic              win_pulse_o,
   output logic              loss_pulse_o
);

   localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HOLD_W = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;

   localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(TICK_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_MS - 1);
   localparam logic [15:0]       TIMEOUT_V  = 16'(TIMEOUT_MS);
   localparam logic [CODE_W:0]   NUM_V      = (CODE_W + 1)'(NUM_LETTERS);
   localparam logic [SCW-1:0]    LAST_ROUND = SCW'(ROUNDS - 1);
   // Right-shifting Galois form of the x^16 + x^14 + x^13 + x^11 + 1 polynomial
   localparam logic [15:0]       LFSR_TAPS  = 16'hB400;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PICK = 3'd1,
      S_PLAY = 3'd2,
      S_WIN  = 3'd3,
      S_LOSS = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t              state_q;
   logic [15:0]         lfsr_q;
   logic [15:0]         lfsr_d;
   logic [DIV_W-1:0]    div_q;
   logic [HOLD_W-1:0]   hold_q;
   logic [CODE_W-1:0]   goal_q;
   logic [SCW-1:0]      score_q;
   logic [15:0]         elapsed_q;
   logic [15:0]         react_q;
   logic [15:0]         best_q;
   logic                win_pulse_q;
   logic                loss_pulse_q;

   logic                tick;
   logic                make;
   logic [CODE_W-1:0]   cand;
   logic                cand_ok;

   always_comb begin
      lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
      tick    = (div_q == DIV_LAST);
      make    = key_valid_i & ~key_break_i;
      cand    = lfsr_q[CODE_W-1:0];
      // A new goal must be a legal letter and must differ from the previous
      // goal, so the player always sees a change between rounds.
      cand_ok = ({1'b0, cand} < NUM_V) && (cand != goal_q);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q      <= S_IDLE;
         lfsr_q       <= LFSR_SEED;
         div_q        <= '0;
         hold_q       <= '0;
         goal_q       <= '0;
         score_q      <= '0;
         elapsed_q    <= '0;
         react_q      <= '0;
         best_q       <= 16'hFFFF;
         win_pulse_q  <= 1'b0;
         loss_pulse_q <= 1'b0;
      end else begin
         lfsr_q       <= lfsr_d;
         win_pulse_q  <= 1'b0;
         loss_pulse_q <= 1'b0;
         // The divider runs freely. Entering PLAY/WIN restarts it, so the
         // first ms of a round or a hold is a full TICK_DIV cycles long.
         div_q        <= tick ? '0 : div_q + DIV_W'(1);

         case (state_q)
            S_IDLE: begin
               if (make) begin
                  score_q <= '0;
                  state_q <= S_PICK;
               end
            end

            S_PICK: begin
               if (cand_ok) begin
                  goal_q    <= cand;
                  elapsed_q <= '0;
                  div_q     <= '0;
                  state_q   <= S_PLAY;
               end
            end

            S_PLAY: begin
               // A key make has priority over a timeout in the same cycle.
               if (make) begin
                  if (key_code_i == goal_q) begin
                     win_pulse_q <= 1'b1;
                     score_q     <= score_q + SCW'(1);
                     react_q     <= elapsed_q;
                     if (elapsed_q < best_q) begin
                        best_q <= elapsed_q;
                     end
                     hold_q  <= '0;
                     div_q   <= '0;
                     state_q <= (score_q == LAST_ROUND) ? S_DONE : S_WIN;
                  end else begin
                     loss_pulse_q <= 1'b1;
                     state_q      <= S_LOSS;
                  end
               end else if (elapsed_q == TIMEOUT_V) begin
                  loss_pulse_q <= 1'b1;
                  state_q      <= S_LOSS;
               end else if (tick && (elapsed_q != 16'hFFFF)) begin
                  elapsed_q <= elapsed_q + 16'd1;
               end
            end

            S_WIN: begin
               if (tick) begin
                  if (hold_q == HOLD_LAST) begin
                     state_q <= S_PICK;
                  end else begin
                     hold_q <= hold_q + HOLD_W'(1);
                  end
               end
            end

            S_LOSS, S_DONE: begin
               if (make) begin
                  score_q <= '0;
                  state_q <= S_PICK;
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign state_o      = state_q;
   assign goal_o       = goal_q;
   assign score_o      = score_q;
   assign elapsed_ms_o = elapsed_q;
   assign react_ms_o   = react_q;
   assign best_ms_o    = best_q;
   assign win_pulse_o  = win_pulse_q;
   assign loss_pulse_o = loss_pulse_q;

endmodule

// File: tb/tb_letter_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_letter_game_ctrl
//   Self-checking bench for letter_game_ctrl with small timing parameters.
//   The reference model keeps the game rules as plain variables: goal, score,
//   reaction times and the ms count derived from cycles spent in PLAY. A
//   free-running LFSR model lets the bench predict every goal letter and the
//   length of each PICK phase.
// -----------------------------------------------------------------------------
module tb_letter_game_ctrl;

   localparam int          CODE_W      = 5;
   localparam int          NUM_LETTERS = 26;
   localparam int          ROUNDS      = 3;
   localparam int          TICK_DIV    = 4;
   localparam int          TIMEOUT_MS  = 10;
   localparam int          HOLD_MS     = 2;
   localparam logic [15:0] SEED        = 16'hACE1;
   localparam int          SCW         = $clog2(ROUNDS + 1);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_PICK = 3'd1;
   localparam logic [2:0] ST_PLAY = 3'd2;
   localparam logic [2:0] ST_WIN  = 3'd3;
   localparam logic [2:0] ST_LOSS = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

   // ---------------- clock / reset ----------------
   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              key_valid = 1'b0;
   logic              key_break = 1'b0;
   logic [CODE_W-1:0] key_code = '0;
   logic [2:0]        state_o;
   logic [CODE_W-1:0] goal_o;
   logic [SCW-1:0]    score_o;
   logic [15:0]       elapsed_ms_o;
   logic [15:0]       react_ms_o;
   logic [15:0]       best_ms_o;
   logic              win_pulse_o;
   logic              loss_pulse_o;

   always #5 clk = ~clk;

   letter_game_ctrl #(
      .CODE_W(CODE_W), .NUM_LETTERS(NUM_LETTERS), .ROUNDS(ROUNDS),
      .TICK_DIV(TICK_DIV), .TIMEOUT_MS(TIMEOUT_MS), .HOLD_MS(HOLD_MS),
      .LFSR_SEED(SEED)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .key_valid_i(key_valid),
      .key_break_i(key_break), .key_code_i(key_code), .state_o(state_o),
      .goal_o(goal_o), .score_o(score_o), .elapsed_ms_o(elapsed_ms_o),
      .react_ms_o(react_ms_o), .best_ms_o(best_ms_o),
      .win_pulse_o(win_pulse_o), .loss_pulse_o(loss_pulse_o)
   );

   // ---------------- reference model ----------------
   int                checks = 0;
   int                failures = 0;
   logic [15:0]       m_lfsr;
   logic [CODE_W-1:0] m_goal;
   int                m_score;
   int                m_react;
   int                m_best;
   int                m_steps;
   int                m_elapsed;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      logic [15:0] r;
      r = v >> 1;
      if (v[0]) r = r ^ 16'hB400;
      return r;
   endfunction

   always @(posedge clk) m_lfsr <= (!rst_n) ? SEED : lfsr_step(m_lfsr);

   task automatic model_reset();
      m_goal = '0; m_score = 0; m_react = 0; m_best = 16'hFFFF; m_steps = 0; m_elapsed = 0;
   endtask

   // Both pulses are never high together.
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (win_pulse_o === 1'b1 && loss_pulse_o === 1'b1) begin
            failures++; $display("FAIL pulse_exclusive: win=%0b loss=%0b required not both", win_pulse_o, loss_pulse_o);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic press(input logic [CODE_W-1:0] code, input logic brk);
      key_valid = 1'b1; key_break = brk; key_code = code;
      step();
      key_valid = 1'b0; key_break = 1'b0;
   endtask

   // Called one cycle after PICK was entered: predicts how long PICK lasts and
   // which letter it settles on, then waits for PLAY.
   task automatic wait_play();
      logic [15:0]       v;
      logic [CODE_W-1:0] prev;
      int                n_exp;
      int                n;
      prev  = m_goal;
      v     = m_lfsr;
      n_exp = 1;
      while (!(int'(v[CODE_W-1:0]) < NUM_LETTERS && v[CODE_W-1:0] != prev) && n_exp < 64) begin
         v = lfsr_step(v); n_exp++;
      end
      n = 0;
      do begin step(); n++; end while (state_o !== ST_PLAY && n < 64);
      checks++;
      if (n != n_exp) begin
         failures++; $display("FAIL pick_cycles: got %0d required %0d", n, n_exp);
      end
      checks++;
      if (goal_o !== v[CODE_W-1:0]) begin
         failures++; $display("FAIL pick_goal: got %0d required %0d", goal_o, v[CODE_W-1:0]);
      end
      checks++;
      if (!(int'(goal_o) < NUM_LETTERS) || goal_o === prev) begin
         failures++; $display("FAIL goal_rule: got %0d previous %0d required <%0d and different", goal_o, prev, NUM_LETTERS);
      end
      m_goal  = v[CODE_W-1:0];
      m_steps = 0; m_elapsed = 0;
   endtask

   task automatic play_for(input int cycles);
      for (int i = 0; i < cycles; i++) step();
      m_steps   = m_steps + cycles;
      m_elapsed = m_steps / TICK_DIV;
      checks++;
      if (state_o !== ST_PLAY || elapsed_ms_o !== 16'(m_elapsed)) begin
         failures++; $display("FAIL play_elapsed: state=%0d elapsed=%0d required state=2 elapsed=%0d", state_o, elapsed_ms_o, m_elapsed);
      end
   endtask

   task automatic hit_goal();
      logic [2:0] exp_state;
      press(m_goal, 1'b0);
      m_score++;
      m_react = m_elapsed;
      if (m_elapsed < m_best) m_best = m_elapsed;
      exp_state = (m_score == ROUNDS) ? ST_DONE : ST_WIN;
      checks++;
      if (win_pulse_o !== 1'b1 || loss_pulse_o !== 1'b0) begin
         failures++; $display("FAIL hit_pulses: win=%0b loss=%0b required win=1 loss=0", win_pulse_o, loss_pulse_o);
      end
      checks++;
      if (state_o !== exp_state || score_o !== SCW'(m_score)) begin
         failures++; $display("FAIL hit_state_score: state=%0d score=%0d required %0d/%0d", state_o, score_o, exp_state, m_score);
      end
      checks++;
      if (react_ms_o !== 16'(m_react) || best_ms_o !== 16'(m_best)) begin
         failures++; $display("FAIL hit_times: react=%0d best=%0d required %0d/%0d", react_ms_o, best_ms_o, m_react, m_best);
      end
   endtask

   // WIN lasts HOLD_MS*TICK_DIV cycles and a make during it changes nothing.
   task automatic finish_win();
      for (int i = 1; i < HOLD_MS * TICK_DIV; i++) begin
         if (i == 3) press(m_goal, 1'b0); else step();
         checks++;
         if (state_o !== ST_WIN || win_pulse_o !== 1'b0) begin
            failures++; $display("FAIL win_hold: cycle %0d state=%0d win=%0b required state=3 win=0", i, state_o, win_pulse_o);
         end
      end
      step();
      checks++;
      if (state_o !== ST_PICK) begin
         failures++; $display("FAIL win_to_pick: state=%0d required 1", state_o);
      end
   endtask

   task automatic restart_from_end();
      press(CODE_W'($urandom_range(0, NUM_LETTERS - 1)), 1'b0);
      m_score = 0;
      checks++;
      if (state_o !== ST_PICK || score_o !== '0) begin
         failures++; $display("FAIL restart: state=%0d score=%0d required 1/0", state_o, score_o);
      end
   endtask

   task automatic wrong_key();
      press(CODE_W'((int'(m_goal) + $urandom_range(1, NUM_LETTERS - 1)) % NUM_LETTERS), 1'b0);
      checks++;
      if (loss_pulse_o !== 1'b1 || win_pulse_o !== 1'b0 || state_o !== ST_LOSS) begin
         failures++; $display("FAIL wrong_key: state=%0d loss=%0b win=%0b required 4/1/0", state_o, loss_pulse_o, win_pulse_o);
      end
      checks++;
      if (score_o !== SCW'(m_score) || goal_o !== m_goal || react_ms_o !== 16'(m_react)) begin
         failures++; $display("FAIL loss_held: score=%0d goal=%0d react=%0d required %0d/%0d/%0d", score_o, goal_o, react_ms_o, m_score, m_goal, m_react);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; step(); step();
      model_reset();
      checks++;
      if (state_o !== ST_IDLE || score_o !== '0 || goal_o !== '0 || best_ms_o !== 16'hFFFF) begin
         failures++; $display("FAIL reset_regs: state=%0d score=%0d goal=%0d best=%0h required 0/0/0/ffff", state_o, score_o, goal_o, best_ms_o);
      end
      checks++;
      if (elapsed_ms_o !== 16'd0 || react_ms_o !== 16'd0 || win_pulse_o !== 1'b0 || loss_pulse_o !== 1'b0) begin
         failures++; $display("FAIL reset_misc: elapsed=%0d react=%0d win=%0b loss=%0b required all 0", elapsed_ms_o, react_ms_o, win_pulse_o, loss_pulse_o);
      end
      rst_n = 1'b1; step();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         press(CODE_W'($urandom_range(0, 31)), 1'b1);
         checks++;
         if (state_o !== ST_IDLE || best_ms_o !== 16'hFFFF) begin
            failures++; $display("FAIL idle_break: state=%0d best=%0h required 0/ffff", state_o, best_ms_o);
         end
      end
   endtask

   task automatic test_win();
      restart_from_end();
      wait_play();
      play_for(3 * TICK_DIV);
      hit_goal();
      checks++;
      if (react_ms_o !== 16'd3 || best_ms_o !== 16'd3 || score_o !== SCW'(1)) begin
         failures++; $display("FAIL first_win: react=%0d best=%0d score=%0d required 3/3/1", react_ms_o, best_ms_o, score_o);
      end
      step();
      checks++;
      if (win_pulse_o !== 1'b0) begin
         failures++; $display("FAIL win_pulse_width: win=%0b required 0", win_pulse_o);
      end
      // hit_goal plus one step already consumed two WIN cycles
      for (int i = 2; i < HOLD_MS * TICK_DIV; i++) step();
      checks++;
      if (state_o !== ST_WIN) begin
         failures++; $display("FAIL win_hold_end: state=%0d required 3", state_o);
      end
      step();
      checks++;
      if (state_o !== ST_PICK) begin
         failures++; $display("FAIL win_after_8: state=%0d required 1", state_o);
      end
   endtask

   task automatic test_wrong_key();
      wait_play();
      play_for($urandom_range(0, 30));
      wrong_key();
      step();
      checks++;
      if (loss_pulse_o !== 1'b0) begin
         failures++; $display("FAIL loss_pulse_width: loss=%0b required 0", loss_pulse_o);
      end
      press(CODE_W'($urandom_range(0, 31)), 1'b1);
      checks++;
      if (state_o !== ST_LOSS) begin
         failures++; $display("FAIL loss_break: state=%0d required 4", state_o);
      end
      restart_from_end();
   endtask

   task automatic test_timeout();
      wait_play();
      play_for(TIMEOUT_MS * TICK_DIV);
      step();
      checks++;
      if (state_o !== ST_LOSS || loss_pulse_o !== 1'b1 || score_o !== SCW'(m_score)) begin
         failures++; $display("FAIL timeout: state=%0d loss=%0b score=%0d required 4/1/%0d", state_o, loss_pulse_o, score_o, m_score);
      end
      restart_from_end();
      wait_play();
      play_for(TIMEOUT_MS * TICK_DIV);
      hit_goal();
      checks++;
      if (react_ms_o !== 16'd10 || state_o !== ST_WIN) begin
         failures++; $display("FAIL timeout_edge_win: react=%0d state=%0d required 10/3", react_ms_o, state_o);
      end
      finish_win();
   endtask

   task automatic test_session();
      int reacts[3] = '{5, 2, 7};
      do_reset();
      restart_from_end();
      for (int r = 0; r < 3; r++) begin
         wait_play();
         play_for(reacts[r] * TICK_DIV + $urandom_range(0, TICK_DIV - 1));
         hit_goal();
         if (r < 2) finish_win();
      end
      checks++;
      if (state_o !== ST_DONE || score_o !== SCW'(3) || react_ms_o !== 16'd7 || best_ms_o !== 16'd2) begin
         failures++; $display("FAIL session_done: state=%0d score=%0d react=%0d best=%0d required 5/3/7/2", state_o, score_o, react_ms_o, best_ms_o);
      end
      press(CODE_W'($urandom_range(0, 31)), 1'b1);
      for (int i = 0; i < 5; i++) step();
      checks++;
      if (state_o !== ST_DONE || score_o !== SCW'(3)) begin
         failures++; $display("FAIL done_held: state=%0d score=%0d required 5/3", state_o, score_o);
      end
      restart_from_end();
   endtask

   task automatic test_random_rounds();
      for (int it = 0; it < 16; it++) begin
         int act;
         wait_play();
         act = $urandom_range(0, 3);
         if (act == 1) begin
            play_for(TIMEOUT_MS * TICK_DIV);
            step();
            checks++;
            if (state_o !== ST_LOSS || loss_pulse_o !== 1'b1) begin
               failures++; $display("FAIL rand_timeout: state=%0d loss=%0b required 4/1", state_o, loss_pulse_o);
            end
            restart_from_end();
         end else begin
            play_for($urandom_range(0, TIMEOUT_MS - 1) * TICK_DIV + $urandom_range(0, TICK_DIV - 1));
            if (act == 0) begin
               wrong_key();
               restart_from_end();
            end else begin
               hit_goal();
               if (m_score == ROUNDS) restart_from_end();
               else finish_win();
            end
         end
      end
   endtask

   task automatic test_reset_mid_play();
      wait_play();
      play_for($urandom_range(2, 8) * TICK_DIV);
      rst_n = 1'b0;
      key_valid = 1'b1; key_break = 1'b0; key_code = m_goal;
      step();
      key_valid = 1'b0;
      model_reset();
      checks++;
      if (state_o !== ST_IDLE || elapsed_ms_o !== 16'd0 || best_ms_o !== 16'hFFFF || score_o !== '0) begin
         failures++; $display("FAIL mid_reset: state=%0d elapsed=%0d best=%0h score=%0d required 0/0/ffff/0", state_o, elapsed_ms_o, best_ms_o, score_o);
      end
      checks++;
      if (win_pulse_o !== 1'b0 || loss_pulse_o !== 1'b0) begin
         failures++; $display("FAIL mid_reset_pulse: win=%0b loss=%0b required 0/0", win_pulse_o, loss_pulse_o);
      end
      rst_n = 1'b1;
      step();
      checks++;
      if (state_o !== ST_IDLE) begin
         failures++; $display("FAIL post_reset_idle: state=%0d required 0", state_o);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_win();
      test_wrong_key();
      test_timeout();
      test_session();
      test_random_rounds();
      test_reset_mid_play();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

endmodule
